unified_mem_arbiter: RTL

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter_pkg.sv | 7 +
 rtl/unified_mem_arbiter_if.sv | 34 +++
 rtl/unified_mem_arbiter_starve_ctr.sv | 19 +
 rtl/unified_mem_arbiter.sv | 68 ++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared types and default constants for the I/D SRAM arbiter
package unified_mem_arbiter_pkg;
  localparam int AWIDTH_DEF = 12;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef enum logic {RD_NONE, RD_PEND} rd_state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, data and SRAM signals shared by the arbiter and its neighbours
interface unified_mem_arbiter_if
  import unified_mem_arbiter_pkg::*;
  #(parameter int AWIDTH = AWIDTH_DEF);
  logic              I_REQ;
  logic [AWIDTH-1:0] I_ADDR;
  logic              I_GNT;
  logic              I_RVALID;
  logic [31:0]       I_RDATA;
  logic              D_REQ;
  logic              D_WEN;
  logic [3:0]        D_BE;
  logic [AWIDTH-1:0] D_ADDR;
  logic [31:0]       D_WDATA;
  logic              D_GNT;
  logic              D_RVALID;
  logic [31:0]       D_RDATA;
  logic              M_CSN;
  logic              M_WEN;
  logic [3:0]        M_BE;
  logic [AWIDTH-1:0] M_ADDR;
  logic [31:0]       M_DI;
  logic [31:0]       M_DOUT;
  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WEN, D_BE, D_ADDR, D_WDATA, M_DOUT,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
    output M_CSN, M_WEN, M_BE, M_ADDR, M_DI
  );
  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WEN, D_BE, D_ADDR, D_WDATA, M_DOUT,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
    input  M_CSN, M_WEN, M_BE, M_ADDR, M_DI
  );
endinterface

// File: rtl/unified_mem_arbiter_starve_ctr.sv
// arb_starve_ctr: counts D wins against a waiting fetch and forces an I grant at the limit
module arb_starve_ctr
  import unified_mem_arbiter_pkg::*;
  #(parameter int STARVE_LIMIT = STARVE_LIMIT_DEF)
  (
  input  logic CLK,
  input  logic RST,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic force_i
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;
  always_ff @(posedge CLK)
    if (RST || i_gnt || !i_req) starve_cnt <= '0;
    else if (d_gnt && starve_cnt != LIM) starve_cnt <= starve_cnt + 4'd1;
  assign force_i = i_req && starve_cnt == LIM;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: D-priority single-port SRAM arbiter with fetch anti-starvation; UNIFIED_MEM_ARBITER_PERF_EN adds perf counters
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
  #(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
  ) (
  input logic CLK,
  input logic RST,
  unified_mem_arbiter_if.slave bus
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
  ,
  output logic [31:0] PERF_CONFLICT,
  output logic [31:0] PERF_STARVE
`endif
);
  logic i_gnt, d_gnt, rd_gnt, rd_live, force_i;
  logic [AWIDTH-1:0] m_addr;
  rd_state_e state, state_n;
  owner_e owner, owner_n;
  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .CLK(CLK),
    .RST(RST),
    .i_req(bus.I_REQ),
    .i_gnt(i_gnt),
    .d_gnt(d_gnt),
    .force_i(force_i)
  );
  always_ff @(posedge CLK)
    if (RST) begin
      state <= RD_NONE;
      owner <= OWN_I;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  // rd_live masks a read granted just before reset so it never returns afterwards
  always_comb begin
    i_gnt = !RST && bus.I_REQ && (!bus.D_REQ || force_i);
    d_gnt = !RST && bus.D_REQ && !i_gnt;
    rd_gnt = i_gnt || (d_gnt && bus.D_WEN);
    state_n = rd_gnt ? RD_PEND : RD_NONE;
    owner_n = i_gnt ? OWN_I : OWN_D;
    rd_live = !RST && state == RD_PEND;
    bus.I_GNT = i_gnt;
    bus.D_GNT = d_gnt;
    bus.I_RVALID = rd_live && owner == OWN_I;
    bus.D_RVALID = rd_live && owner == OWN_D;
    bus.I_RDATA = bus.I_RVALID ? bus.M_DOUT : '0;
    bus.D_RDATA = bus.D_RVALID ? bus.M_DOUT : '0;
    bus.M_CSN = !(i_gnt || d_gnt);
    bus.M_WEN = d_gnt ? bus.D_WEN : 1'b1;
    bus.M_BE = d_gnt ? bus.D_BE : 4'b0000;
    m_addr = i_gnt ? bus.I_ADDR : d_gnt ? bus.D_ADDR : '0;
    bus.M_ADDR = m_addr;
    bus.M_DI = d_gnt ? bus.D_WDATA : '0;
  end
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
  always_ff @(posedge CLK)
    if (RST) begin
      PERF_CONFLICT <= '0;
      PERF_STARVE <= '0;
    end else begin
      if (bus.I_REQ && bus.D_REQ) PERF_CONFLICT <= PERF_CONFLICT + 32'd1;
      if (i_gnt && bus.D_REQ) PERF_STARVE <= PERF_STARVE + 32'd1;
    end
`endif
endmodule
